// File: rtl/fir_mac_serial.sv
// Time-multiplexed FIR: sliced sample input, one shared multiplier, rounded output.
// Build option FIR_SAT_EN clamps the rounded result instead of wrapping it.
module fir_mac_serial #(
  parameter int TAPS  = 16,
  parameter int DW    = 8,
  parameter int IN_W  = 4,
  parameter int CW    = 16,
  parameter int FRAC  = 12,
  parameter int OUT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     x_valid,
  input  logic [IN_W-1:0]          x_slice,
  output logic                     x_ready,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [CW-1:0]            coef_wdata,
  output logic                     coef_err,
  output logic                     busy,
  output logic                     z_valid,
  output logic [OUT_W-1:0]         z
);
  localparam int NS  = DW / IN_W;
  localparam int SCW = (NS > 1) ? $clog2(NS) : 1;
  localparam int AW  = $clog2(TAPS);
  localparam int ACW = DW + CW + AW;
  localparam int PW  = DW + CW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [SCW-1:0]          scnt_q, scnt_d;
  logic [DW-1:0]           asm_q, asm_d, smp;
  logic [AW-1:0]           k_q, k_d;
  logic signed [ACW-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]        z_q, z_d, zconv;
  logic                    zv_q, err_q;
  logic signed [DW-1:0]    xl_q [TAPS];
  logic signed [CW-1:0]    h_q  [TAPS];
  logic signed [PW-1:0]    prod;
  logic                    accept, last_slice, addr_ok, wr_ok;

  assign x_ready    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign busy       = (state_q == S_MAC) || (state_q == S_OUT);
  assign accept     = x_valid && x_ready;
  assign last_slice = (scnt_q == SCW'(NS - 1));
  assign prod       = xl_q[k_q] * h_q[k_q];
  assign addr_ok    = ({1'b0, coef_addr} < (AW+1)'(TAPS));
  assign wr_ok      = coef_we && !busy && addr_ok;
  assign z          = z_q;
  assign z_valid    = zv_q;
  assign coef_err   = err_q;

  always_comb begin
    smp = asm_q;
    smp[IN_W*scnt_q +: IN_W] = x_slice;
  end

  // Round half up: floor(acc / 2^FRAC) plus the first discarded bit.
`ifdef FIR_SAT_EN
  localparam int RW = ACW - FRAC;
  localparam logic signed [RW-1:0] ZMAX = (RW'(1) << (OUT_W-1)) - RW'(1);
  localparam logic signed [RW-1:0] ZMIN = ~ZMAX;
  logic signed [RW-1:0] rnd;
  assign rnd   = acc_q[ACW-1:FRAC] + RW'(acc_q[FRAC-1]);
  assign zconv = (rnd > ZMAX) ? ZMAX[OUT_W-1:0] :
                 (rnd < ZMIN) ? ZMIN[OUT_W-1:0] : rnd[OUT_W-1:0];
`else
  assign zconv = acc_q[FRAC+OUT_W-1:FRAC] + OUT_W'(acc_q[FRAC-1]);
`endif

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    asm_d   = asm_q;
    k_d     = k_q;
    acc_d   = acc_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          asm_d = smp;
          if (last_slice) begin
            state_d = S_MAC;
            scnt_d  = '0;
            acc_d   = '0;
            k_d     = '0;
          end else begin
            state_d = S_LOAD;
            scnt_d  = scnt_q + SCW'(1);
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACW'(prod);
        if (k_q == AW'(TAPS - 1)) state_d = S_OUT;
        else                      k_d     = k_q + AW'(1);
      end
      S_OUT: begin
        z_d     = zconv;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      scnt_q  <= '0;
      asm_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
      zv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      asm_q   <= asm_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      zv_q    <= (state_q == S_OUT);
      err_q   <= coef_we && !wr_ok;
    end
  end

  // Delay line advances only when a complete sample has been assembled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) xl_q[i] <= '0;
    end else if (accept && last_slice) begin
      xl_q[0] <= smp;
      for (int i = 1; i < TAPS; i++) xl_q[i] <= xl_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) h_q[i] <= '0;
    end else if (wr_ok) begin
      h_q[coef_addr] <= coef_wdata;
    end
  end
endmodule

// File: tb/tb_fir_mac_serial.sv
// Randomized self-checking bench for fir_mac_serial against a sum-of-products model.
module tb_fir_mac_serial;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        x_valid = 1'b0;
  logic [3:0]  x_slice = '0;
  logic        x_ready;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        coef_err, busy, z_valid;
  logic [7:0]  z;

  logic        c2_ready, c2_we = 1'b0, c2_err, c2_busy, c2_zv;
  logic [3:0]  c2_addr = '0;
  logic [7:0]  c2_z;

  int n_vec = 0, n_err = 0;
  int hist[16], hc[16];

  always #5 clk = ~clk;

  fir_mac_serial #(.TAPS(16), .DW(8), .IN_W(4), .CW(16), .FRAC(12), .OUT_W(8)) dut (
    .clk(clk), .reset(reset), .x_valid(x_valid), .x_slice(x_slice), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_err(coef_err),
    .busy(busy), .z_valid(z_valid), .z(z));

  // Non-power-of-two tap count so an out-of-range address is representable.
  fir_mac_serial #(.TAPS(10), .DW(8), .IN_W(4), .CW(16), .FRAC(12), .OUT_W(8)) dut2 (
    .clk(clk), .reset(reset), .x_valid(1'b0), .x_slice(4'h0), .x_ready(c2_ready),
    .coef_we(c2_we), .coef_addr(c2_addr), .coef_wdata(16'h1234), .coef_err(c2_err),
    .busy(c2_busy), .z_valid(c2_zv), .z(c2_z));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int model_z();
    longint acc = 0;
    longint r;
    for (int k = 0; k < 16; k++) acc += longint'(hist[k]) * longint'(hc[k]);
    r = (acc + 2048) >>> 12;
`ifdef FIR_SAT_EN
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
`endif
    return int'(r) & 255;
  endfunction

  task automatic wcoef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 4'(a); coef_wdata = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
    chk("coef_err_idle", coef_err, 0);
    hc[a] = v;
  endtask

  task automatic set_h0(input int v);
    for (int k = 0; k < 16; k++) wcoef(k, (k == 0) ? v : 0);
  endtask

  // mode 0: plain, 1: coefficient write during MAC, 2: reset during MAC
  task automatic run(input logic [7:0] x, input int gap, input int mode);
    int t = 0;
    int lat = 0;
    while (!x_ready && t < 50) begin @(negedge clk); t++; end
    if (!x_ready) chk("ready_timeout", 0, 1);
    x_valid = 1'b1; x_slice = x[3:0];
    @(negedge clk);
    x_valid = 1'b0;
    repeat (gap) @(negedge clk);
    x_valid = 1'b1; x_slice = x[7:4];
    @(negedge clk);
    x_valid = 1'b0;
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin
        chk("mac_busy", busy, 1);
        chk("mac_x_ready", x_ready, 0);
      end
      if (mode == 1) begin
        if (lat == 5) begin coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'h0000; end
        if (lat == 6) begin coef_we = 1'b0; chk("coef_err_pulse", coef_err, 1); end
        if (lat == 7) chk("coef_err_once", coef_err, 0);
      end
      if (mode == 2 && lat == 7) begin
        reset = 1'b1;
        #1;
        chk("rst_z", z, 0);
        chk("rst_z_valid", z_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x_ready", x_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin hist[k] = 0; hc[k] = 0; end
        return;
      end
      if (z_valid) break;
    end
    chk("latency", lat, 17);
    chk("z", z, model_z());
    @(negedge clk);
    chk("z_valid_pulse", z_valid, 0);
    chk("z_hold", z, model_z());
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin hist[k] = 0; hc[k] = 0; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_z", z, 0);
    chk("reset_z_valid", z_valid, 0);
    chk("reset_x_ready", x_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_coef_err", coef_err, 0);

    // passthrough
    set_h0(16'h1000);
    run(8'h25, 0, 0);

    // impulse response through the programmed taps
    for (int k = 0; k < 16; k++) wcoef(k, int'($signed(16'(k << 12))));
    run(8'h01, 0, 0);
    for (int i = 0; i < 15; i++) run(8'h00, 0, 0);

    // rounding at the half point, both signs
    set_h0(16'h0800);
    run(8'h03, 0, 0);
    run(8'hFD, 0, 0);

    // overflow of the output range
    set_h0(16'h7FFF);
    run(8'h7F, 0, 0);

    // coefficient write while busy is dropped
    run(8'h11, 0, 1);
    run(8'h22, 0, 0);

    // out-of-range address on the 10-tap instance
    c2_we = 1'b1; c2_addr = 4'd10;
    @(negedge clk);
    c2_we = 1'b0;
    chk("oob_err", c2_err, 1);
    @(negedge clk);
    chk("oob_err_once", c2_err, 0);
    c2_we = 1'b1; c2_addr = 4'd9;
    @(negedge clk);
    c2_we = 1'b0;
    chk("inrange_no_err", c2_err, 0);

    // stalls between slices
    run(8'h5A, 3, 0);
    run(8'hC3, 1, 0);

    // reset mid-MAC, then restart on a cleared delay line
    set_h0(16'h1000);
    wcoef(1, 16'h1000);
    run(8'h40, 0, 0);
    run(8'h33, 0, 2);
    wcoef(0, 16'h1000);
    wcoef(1, 16'h1000);
    run(8'h12, 0, 0);

    // randomized coefficients, samples and gaps
    for (int i = 0; i < 25; i++) begin
      repeat (2) wcoef($urandom_range(0, 15), $urandom_range(0, 65535) - 32768);
      run(8'($urandom_range(0, 255)), $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
